regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised multi-port integer register file with a write-back scoreboard. It is the decode-stage operand source for the dual-issue pipeline:
- N read ports serve operand fetch.
- M write ports accept write-back.
- A per-register busy bit tracks destinations claimed at issue and not yet written back.
- An optional same-cycle write-to-read bypass is provided.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; NREG = 2**ADDR_W registers
- NREAD, 2, number of read ports
- NWRITE, 2, number of write-back ports
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return array contents only
- ZERO_REG, 1, 1 = register 0 hardwired to zero, never busy, writes/issues to it ignored

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- rd_addr  input  NREAD*ADDR_W  read indices, port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  output  NREAD*DATA_W  read data, combinational
- rd_busy  output  NREAD  register at rd_addr[k] has an outstanding write, combinational
- wr_en  input  NWRITE  write-back enable per port
- wr_addr  input  NWRITE*ADDR_W  write-back index per port
- wr_data  input  NWRITE*DATA_W  write-back data per port
- iss_en  input  1  claim a destination register (set busy)
- iss_addr  input  ADDR_W  destination being claimed
- flush  input  1  synchronous clear of all busy bits (pipeline flush); array data kept
- busy_cnt  output  ADDR_W+1  registered count of busy registers

## Operation
- Reset (reset low, asynchronous):
  - All NREG registers clear to 0.
  - All busy bits clear.
  - busy_cnt = 0.
- Write:
  - On a rising edge, each port j with wr_en[j]=1 writes wr_data[j] to rf[wr_addr[j]].
  - When several enabled ports target the same address, the highest-index port wins.
  - With ZERO_REG=1, writes to index 0 are dropped.
- Read data for port k, in priority order:
  1. ZERO_REG=1 and rd_addr[k]=0 -> 0.
  2. BYPASS=1 and some enabled write port matches rd_addr[k] -> wr_data of the highest-index matching port.
  3. Otherwise -> rf[rd_addr[k]].
- Read busy for port k:
  - rd_busy[k] = busy[rd_addr[k]].
  - With BYPASS=1, rd_busy[k] is masked to 0 when an enabled write port targets that address in the same cycle.
  - With BYPASS=0, there is no masking.
  - With ZERO_REG=1, index 0 always reads not-busy.
- Busy next-state per register r, in priority order:
  1. flush=1 -> 0. Flush also overrides iss_en in the same cycle.
  2. iss_en=1 and iss_addr=r -> 1. Issue wins over a same-cycle write-back to r; the new producer owns r.
  3. Any enabled write port with wr_addr=r -> 0.
  4. Otherwise hold.
- Issue to index 0 with ZERO_REG=1 is ignored.
- busy_cnt is registered and equals the popcount of the busy vector after the edge. Range 0..NREG (NREG only when ZERO_REG=0). It never wraps.
- A write-back to a non-busy register is legal: data is written, busy stays 0.

## Timing
- Read path fully combinational: rd_data and rd_busy settle in the same cycle as rd_addr/wr_*.
- Write latency: 1 cycle. The value is visible from the array on the cycle after the write edge, or in the same cycle via bypass when BYPASS=1.
- Busy set/clear takes effect at the edge. rd_busy reflects it from the next cycle (the bypass mask excepted).
- busy_cnt lags the busy-vector update by 0 cycles; both are registered on the same edge.
- Reset mid-operation:
  - Asserting reset clears the array and busy bits immediately, regardless of the clock.
  - Writes, issues and flushes in flight are lost.
  - The first write is accepted on the first rising edge after reset deasserts.

## Test plan
- Reset sequence, then read all 32 registers on both ports -> every rd_data = 0, rd_busy = 0, busy_cnt = 0.
- Write x5=0xDEADBEEF on port 0, then read x5 on port 1 next cycle -> 0xDEADBEEF. With BYPASS=1, the same-cycle read also returns 0xDEADBEEF. With BYPASS=0, the same-cycle read returns the old value 0.
- Both write ports target x7 in one cycle (port0=0x11, port1=0x22) -> x7 reads 0x22. Write x0=0x55 -> x0 still reads 0.
- iss x3, then iss x4 -> busy_cnt 1 then 2, rd_busy high for x3/x4. Write-back x3 -> rd_busy masked the same cycle, busy_cnt = 1 after the edge.
- Same cycle: iss x9 and write-back x9 while x9 is busy -> x9 remains busy, data updated, busy_cnt unchanged.
- Claim x1, x2, x3 (busy_cnt=3), then flush together with iss x10 -> all busy clear, busy_cnt=0. Register contents unchanged. Assert reset asynchronously mid-cycle -> outputs return to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port integer register file with a write-back scoreboard.
// Read ports are purely combinational. They can optionally forward same-cycle
// write-back data. A per-register busy bit marks destinations that were claimed
// at issue and have not yet been written back.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREAD*ADDR_W-1:0]  rd_addr,
    output logic [NREAD*DATA_W-1:0]  rd_data,
    output logic [NREAD-1:0]         rd_busy,
    input  logic [NWRITE-1:0]        wr_en,
    input  logic [NWRITE*ADDR_W-1:0] wr_addr,
    input  logic [NWRITE*DATA_W-1:0] wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     flush,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int NREG = 2 ** ADDR_W;

    // Register 0 is a constant when ZERO_REG is set. Any write, issue or busy
    // state aimed at it is discarded.
    function automatic logic addr_live(input logic [ADDR_W-1:0] a);
        return (ZERO_REG == 0) || (a != '0);
    endfunction

    // Number of set bits in a busy vector. The result width holds NREG itself.
    function automatic logic [ADDR_W:0] popcount(input logic [NREG-1:0] v);
        logic [ADDR_W:0] c;
        c = '0;
        for (int i = 0; i < NREG; i++) begin
            c = c + {{ADDR_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    logic [DATA_W-1:0] rf [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;
    logic [ADDR_W:0]   busy_cnt_q;

    logic [ADDR_W-1:0] ra [NREAD];
    logic [ADDR_W-1:0] wa [NWRITE];
    logic [DATA_W-1:0] wd [NWRITE];
    logic [NWRITE-1:0] we;

    logic [DATA_W-1:0] rdd [NREAD];
    logic              rdb [NREAD];

    // Unpack the flat port buses into per-port indices and data.
    // Write enables aimed at a hardwired zero register are dropped here.
    always_comb begin
        for (int k = 0; k < NREAD; k++) begin
            ra[k] = rd_addr[k*ADDR_W +: ADDR_W];
        end
        we = '0;
        for (int j = 0; j < NWRITE; j++) begin
            wa[j] = wr_addr[j*ADDR_W +: ADDR_W];
            wd[j] = wr_data[j*DATA_W +: DATA_W];
            we[j] = wr_en[j] && addr_live(wa[j]);
        end
    end

    // Register array update. Ports are applied in ascending order, so the
    // highest-index port wins when several ports hit the same register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else begin
            for (int j = 0; j < NWRITE; j++) begin
                if (we[j]) begin
                    rf[wa[j]] <= wd[j];
                end
            end
        end
    end

    // Scoreboard next state. Later assignments take priority:
    // a write-back clears a bit, an issue then sets it, and a flush clears all bits.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NWRITE; j++) begin
            if (wr_en[j]) begin
                busy_d[wa[j]] = 1'b0;
            end
        end
        if (iss_en) begin
            busy_d[iss_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    // The busy vector and its population count are registered on the same edge,
    // so busy_cnt never lags the scoreboard.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= popcount(busy_d);
        end
    end

    // Combinational read ports: zero register first, then the same-cycle
    // bypass (which also hides the busy bit being retired), then the array.
    always_comb begin
        for (int k = 0; k < NREAD; k++) begin
            rdd[k] = rf[ra[k]];
            rdb[k] = busy_q[ra[k]];
            if (BYPASS != 0) begin
                for (int j = 0; j < NWRITE; j++) begin
                    if (wr_en[j] && (wa[j] == ra[k])) begin
                        rdd[k] = wd[j];
                        rdb[k] = 1'b0;
                    end
                end
            end
            if (!addr_live(ra[k])) begin
                rdd[k] = '0;
                rdb[k] = 1'b0;
            end
        end
    end

    // Repack per-port read results onto the flat output buses.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NREAD; k++) begin
            rd_data[k*DATA_W +: DATA_W] = rdd[k];
            rd_busy[k]                  = rdb[k];
        end
    end

    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed and random stimulus for regfile_sb.
// A behavioural register file plus scoreboard model supplies the expected values.
module tb_regfile_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREAD  = 2;
    localparam int NWRITE = 2;
    localparam int NREG   = 32;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NREAD*ADDR_W-1:0]  rd_addr;
    logic [NREAD*DATA_W-1:0]  rd_data;
    logic [NREAD-1:0]         rd_busy;
    logic [NWRITE-1:0]        wr_en;
    logic [NWRITE*ADDR_W-1:0] wr_addr;
    logic [NWRITE*DATA_W-1:0] wr_data;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     flush;
    logic [ADDR_W:0]          busy_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] m_rf [NREG];
    bit                m_busy [NREG];

    regfile_sb #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREAD(NREAD), .NWRITE(NWRITE),
        .BYPASS(1), .ZERO_REG(1)
    ) dut (
        .clk(clk), .reset(reset),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
        .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of test, expected finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_data(input int k);
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] r;
        a = rd_addr[k*ADDR_W +: ADDR_W];
        if (a == 0) return '0;
        r = m_rf[a];
        for (int j = 0; j < NWRITE; j++)
            if (wr_en[j] && wr_addr[j*ADDR_W +: ADDR_W] == a) r = wr_data[j*DATA_W +: DATA_W];
        return r;
    endfunction

    function automatic logic exp_busy(input int k);
        logic [ADDR_W-1:0] a;
        a = rd_addr[k*ADDR_W +: ADDR_W];
        if (a == 0) return 1'b0;
        for (int j = 0; j < NWRITE; j++)
            if (wr_en[j] && wr_addr[j*ADDR_W +: ADDR_W] == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < NREG; i++) if (m_busy[i]) c++;
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_rf[i]   = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Apply what the rising edge does to the model, using the inputs currently driven.
    task automatic model_edge();
        for (int j = 0; j < NWRITE; j++) begin
            if (wr_en[j] && wr_addr[j*ADDR_W +: ADDR_W] != 0)
                m_rf[wr_addr[j*ADDR_W +: ADDR_W]] = wr_data[j*DATA_W +: DATA_W];
        end
        if (flush) begin
            for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
        end else begin
            for (int j = 0; j < NWRITE; j++)
                if (wr_en[j]) m_busy[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
            if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
        end
        m_busy[0] = 1'b0;
    endtask

    task automatic check_reads();
        for (int k = 0; k < NREAD; k++) begin
            chk($sformatf("rd_data%0d", k), 64'(rd_data[k*DATA_W +: DATA_W]), 64'(exp_data(k)));
            chk($sformatf("rd_busy%0d", k), 64'(rd_busy[k]), 64'(exp_busy(k)));
        end
    endtask

    // One clock cycle: check the combinational reads, take the edge, then check the count.
    task automatic step();
        #2;
        check_reads();
        @(posedge clk);
        model_edge();
        #1;
        chk("busy_cnt", 64'(busy_cnt), 64'(m_count()));
        @(negedge clk);
    endtask

    task automatic idle();
        wr_en  = '0;
        iss_en = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic rd(input int a0, input int a1);
        rd_addr = {ADDR_W'(a1), ADDR_W'(a0)};
    endtask

    task automatic wr(input int j, input int a, input logic [DATA_W-1:0] d);
        wr_en[j]                    = 1'b1;
        wr_addr[j*ADDR_W +: ADDR_W] = ADDR_W'(a);
        wr_data[j*DATA_W +: DATA_W] = d;
    endtask

    task automatic iss(input int a);
        iss_en   = 1'b1;
        iss_addr = ADDR_W'(a);
    endtask

    function automatic int rand_addr();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, NREG - 1));
        return int'($urandom_range(0, 7));
    endfunction

    initial begin
        reset = 1'b0;
        idle();
        rd(0, 0);
        wr_addr  = '0;
        wr_data  = '0;
        iss_addr = '0;
        model_reset();
        #12;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("reset_busy_cnt", 64'(busy_cnt), 64'd0);
        for (int i = 0; i < NREG; i++) begin
            rd(i, i);
            #1;
            chk($sformatf("reset_rd_x%0d", i), 64'(rd_data), 64'd0);
            chk($sformatf("reset_busy_x%0d", i), 64'(rd_busy), 64'd0);
        end

        // Write x5, with a same-cycle bypass read and a next-cycle array read.
        idle(); wr(0, 5, 32'hDEADBEEF); rd(5, 5);
        #1; chk("bypass_x5", 64'(rd_data[63:32]), 64'hDEADBEEF);
        step();
        idle(); rd(0, 5);
        #1; chk("array_x5", 64'(rd_data[63:32]), 64'hDEADBEEF);
        step();

        // Two ports hit x7, then try to write x0.
        idle(); wr(0, 7, 32'h11); wr(1, 7, 32'h22); rd(1, 2);
        step();
        idle(); rd(7, 0); wr(0, 0, 32'h55);
        #1; chk("x7_port1_wins", 64'(rd_data[31:0]), 64'h22);
        chk("x0_bypass_zero", 64'(rd_data[63:32]), 64'd0);
        step();
        idle(); rd(0, 0);
        #1; chk("x0_stays_zero", 64'(rd_data), 64'd0);
        step();

        // Claim x3 and x4, then retire x3.
        idle(); iss(3); step();
        chk("cnt_after_iss3", 64'(busy_cnt), 64'd1);
        iss(4); step();
        chk("cnt_after_iss4", 64'(busy_cnt), 64'd2);
        idle(); rd(3, 4);
        #1; chk("busy_x3_x4", 64'(rd_busy), 64'b11);
        step();
        wr(0, 3, 32'h33); rd(3, 4);
        #1; chk("busy_x3_masked", 64'(rd_busy), 64'b10);
        step();
        chk("cnt_after_wb3", 64'(busy_cnt), 64'd1);

        // Issue and write back x9 in the same cycle while x9 is busy.
        idle(); iss(9); step();
        idle(); iss(9); wr(1, 9, 32'h99); rd(9, 9);
        step();
        chk("cnt_iss_wb_x9", 64'(busy_cnt), 64'd2);
        idle(); rd(9, 9);
        #1; chk("busy_x9_kept", 64'(rd_busy), 64'b11);
        chk("data_x9", 64'(rd_data[31:0]), 64'h99);
        step();

        // Flush, claim three registers, then flush together with an issue.
        idle(); flush = 1'b1; step();
        chk("cnt_after_flush", 64'(busy_cnt), 64'd0);
        idle(); iss(1); step();
        iss(2); step();
        iss(3); step();
        chk("cnt_three", 64'(busy_cnt), 64'd3);
        idle(); flush = 1'b1; iss(10); step();
        chk("cnt_flush_iss", 64'(busy_cnt), 64'd0);
        idle(); rd(10, 7);
        #1; chk("x10_not_busy", 64'(rd_busy), 64'd0);
        chk("x7_kept", 64'(rd_data[63:32]), 64'h22);
        step();

        // Random traffic checked against the model every cycle.
        for (int n = 0; n < 400; n++) begin
            idle();
            rd(rand_addr(), rand_addr());
            for (int j = 0; j < NWRITE; j++) begin
                if ($urandom_range(0, 1) == 1) wr(j, rand_addr(), $urandom());
            end
            if ($urandom_range(0, 2) == 0) iss(rand_addr());
            flush = ($urandom_range(0, 19) == 0);
            step();
        end

        // Asynchronous reset in the middle of the low phase.
        idle(); iss(12); step();
        idle(); wr(0, 20, 32'h1234); step();
        idle(); rd(20, 12);
        #1; chk("pre_reset_x20", 64'(rd_data[31:0]), 64'h1234);
        #2; reset = 1'b0;
        #1; chk("async_rst_data", 64'(rd_data), 64'd0);
        chk("async_rst_busy", 64'(rd_busy), 64'd0);
        chk("async_rst_cnt", 64'(busy_cnt), 64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        wr(0, 13, 32'hCAFE); rd(13, 20);
        step();
        idle(); rd(13, 20);
        #1; chk("first_write_after_rst", 64'(rd_data[31:0]), 64'hCAFE);
        chk("x20_cleared", 64'(rd_data[63:32]), 64'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
